lsu_axil_master: RTL and testbench
==================================

// Module: lsu_axil_master
// PURPOSE
//   AXI4-Lite initiator bridging the core's single-outstanding load/store request port to the system bus
//   (CLINT, SRAM, UART responders). Accepts one request, runs exactly one AR/R or AW/W/B transaction,
//   returns a one-cycle response pulse carrying read data and error status.
// PARAMETERS
//   ADDR_W   32  request/bus address width
//   DATA_W   32  data width; fixed at 32, WSTRB width DATA_W/8
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       synchronous, active-high reset
//   req_valid  in   1       core request valid
//   req_ready  out  1       bridge idle, request accepted when req_valid & req_ready
//   req_wen    in   1       1 = store, 0 = load
//   req_size   in   2       0 byte, 1 half, 2 word (3 treated as word)
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   DATA_W  store data, already lane-aligned
//   req_wmask  in   4       store byte strobes
//   rsp_valid  out  1       one-cycle completion pulse
//   rsp_rdata  out  DATA_W  load data (0 for stores/errors)
//   rsp_err    out  1       1 = bus error (RRESP/BRESP != 2'b00) or local reject
//   ARVALID/ARREADY/ARADDR, RVALID/RREADY/RDATA/RRESP: read channels (out/in/out, in/out/in/in)
//   AWVALID/AWREADY/AWADDR, WVALID/WREADY/WDATA/WSTRB, BVALID/BREADY/BRESP: write channels
// BEHAVIOUR
//   - States: IDLE, AR, R, WR (AW+W), B, RESP. Reset -> IDLE; all VALID/READY outs, rsp_* = 0.
//   - IDLE: req_ready=1. On accept (cycle T) latch addr/wdata/wmask/wen; T+1 enters AR (load) or WR (store).
//   - AR: ARVALID=1, ARADDR=latched addr, held stable until ARREADY; then -> R.
//   - R: RREADY=1; on RVALID latch RDATA and err=(RRESP!=0); -> RESP.
//   - WR: AWVALID and WVALID raised together; each drops independently the cycle after its own
//     handshake (aw_done/w_done flags); either order or simultaneous accepted; both done -> B.
//   - B: BREADY=1; on BVALID latch err=(BRESP!=0); -> RESP.
//   - RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err valid; -> IDLE. No core backpressure.
//   - Min latency: load accept T -> rsp_valid T+3 with zero-wait responder; store same.
//   - Addresses/data never change while the corresponding VALID is high without handshake.
//   - Outputs driven from registered state; no combinational path req_* -> AXI outputs.
//   - WSTRB = req_wmask verbatim; AWADDR/ARADDR not re-aligned.
//   - RRESP/BRESP SLVERR(2'b10) and DECERR(2'b11) both give rsp_err=1, rsp_rdata=0.
//   - Reset mid-transaction: next edge returns to IDLE, all VALIDs low; transaction abandoned
//     (responders share rst, so no stale beats).
//   - req_valid outside IDLE ignored (req_ready=0).
// CONFIGURATION
//   MISALIGN_CHECK_EN defined: in IDLE, half with addr[0]!=0 or word with addr[1:0]!=0 is not
//     forwarded; T+1 enters RESP directly with rsp_err=1, rsp_rdata=0; no AXI channel toggles.
//   Undefined: all requests forwarded unchanged; alignment is responder's problem.
// TESTING
//   - Load 0x0200_BFF8, ARREADY=1, RVALID same cycle as RREADY, RDATA=0x0000_1234, RRESP=0
//     -> rsp_valid 1 cycle at T+3, rsp_rdata=0x1234, rsp_err=0.
//   - Store 0x8000_0010 data 0xDEAD_BEEF mask 0xF, AWREADY 3 cycles before WREADY
//     -> AWVALID drops after AW handshake, WVALID held stable until WREADY, single rsp_valid after BVALID.
//   - Load with RRESP=2'b10 -> rsp_err=1, rsp_rdata=0; store with BRESP=2'b10 -> rsp_err=1.
//   - ARREADY low 5 cycles -> ARVALID/ARADDR stable all 5 cycles, req_ready=0 throughout.
//   - rst asserted while in B -> next cycle IDLE, BREADY=0, no rsp_valid pulse.
//   - MISALIGN_CHECK_EN: word load at 0x8000_0002 -> rsp_err=1 at T+1 (RESP entered), ARVALID never 1;
//     macro off -> ARADDR=0x8000_0002 issued.

Source files
------------

// File: rtl/lsu_axil_master.sv
// AXI4-Lite initiator: one core load/store request -> one AR/R or AW/W/B transaction -> one response pulse.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned half/word requests locally without touching the bus.
`timescale 1ns/1ps
module lsu_axil_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [3:0]            req_wmask,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  // req_size only matters when local alignment checking is built in.
  logic unused_req_size;
  assign unused_req_size = ^req_size;

`ifdef MISALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (req_size == 2'd1) begin
      misaligned = req_addr[0];
    end else if (req_size != 2'd0) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wmask_d   = req_wmask;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? S_WR : S_AR;
`ifdef MISALIGN_CHECK_EN
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_AR: begin
        if (ARREADY) begin
          state_d = S_R;
        end
      end
      S_R: begin
        if (RVALID) begin
          err_d   = (RRESP != 2'b00);
          rdata_d = (RRESP == 2'b00) ? RDATA : '0;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        // A channel already done ignores its READY; each VALID drops once its own beat is taken.
        aw_done_d = aw_done_q | AWREADY;
        w_done_d  = w_done_q | WREADY;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (BVALID) begin
          err_d   = (BRESP != 2'b00);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Every bus-facing output decodes registered state only.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign ARVALID   = (state_q == S_AR);
  assign ARADDR    = addr_q;
  assign RREADY    = (state_q == S_R);
  assign AWVALID   = (state_q == S_WR) && !aw_done_q;
  assign AWADDR    = addr_q;
  assign WVALID    = (state_q == S_WR) && !w_done_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wmask_q;
  assign BREADY    = (state_q == S_B);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Scoreboard bench for lsu_axil_master: randomized requests, a word-array memory model and an AXI-Lite responder.
`timescale 1ns/1ps
module tb_lsu_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] ARADDR, RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;

  always #5 clk = ~clk;

  lsu_axil_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

`ifdef MISALIGN_CHECK_EN
  localparam bit MISALIGN_ON = 1'b1;
`else
  localparam bit MISALIGN_ON = 1'b0;
`endif

  typedef struct {
    bit          wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [1:0]  resp;
    int          ar_w, r_w, aw_w, w_w, b_w;
    bit          nobus;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  bit          saw_bus = 1'b0;
  plan_t       cur;
  exp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] resp_mem  [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops one expectation per response pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_latency", cyc, e.lat);
          $display("rsp cycle %0d rdata=0x%08h err=%0d", cyc, rsp_rdata, rsp_err);
        end
        rsp_cnt++;
      end
    end
  end

  // Responder: decides READY/VALID at the negedge, so each decision is what the DUT sees at the next posedge.
  initial begin : responder
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_f, r_f, aw_f, w_f, b_f;
    logic [31:0] ar_a0, aw_a0, w_d0, rd_data, aw_got, w_got;
    logic [3:0]  w_s0, s_got;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
    ar_a0 = 0; aw_a0 = 0; w_d0 = 0; rd_data = 0; aw_got = 0; w_got = 0; w_s0 = 0; s_got = 0;
    forever begin
      @(negedge clk);
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      if (rst || rsp_valid) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
      end else begin
        if (ARVALID || AWVALID || WVALID) saw_bus = 1'b1;
        if (ar_f) chk("arvalid_drop", {31'd0, ARVALID}, 32'd0);
        if (aw_f) chk("awvalid_drop", {31'd0, AWVALID}, 32'd0);
        if (w_f)  chk("wvalid_drop",  {31'd0, WVALID},  32'd0);
        if (ARVALID && !ar_f) begin
          if (ar_cnt == 0) ar_a0 = ARADDR;
          else begin
            chk("araddr_stable", ARADDR, ar_a0);
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
          end
          if (ar_cnt >= cur.ar_w) begin
            ARREADY = 1; ar_f = 1;
            chk("araddr", ARADDR, cur.addr);
            rd_data = resp_mem[ARADDR[5:2]];
          end
          ar_cnt++;
        end
        if (RREADY && ar_f && !r_f) begin
          if (r_cnt >= cur.r_w) begin
            RVALID = 1; RRESP = cur.resp; RDATA = rd_data; r_f = 1;
          end
          r_cnt++;
        end
        if (AWVALID && !aw_f) begin
          if (aw_cnt == 0) aw_a0 = AWADDR;
          else chk("awaddr_stable", AWADDR, aw_a0);
          if (aw_cnt >= cur.aw_w) begin
            AWREADY = 1; aw_f = 1; aw_got = AWADDR;
            chk("awaddr", AWADDR, cur.addr);
          end
          aw_cnt++;
        end
        if (WVALID && !w_f) begin
          if (w_cnt == 0) begin w_d0 = WDATA; w_s0 = WSTRB; end
          else begin
            chk("wdata_stable", WDATA, w_d0);
            chk("wstrb_stable", {28'd0, WSTRB}, {28'd0, w_s0});
          end
          if (w_cnt >= cur.w_w) begin
            WREADY = 1; w_f = 1; w_got = WDATA; s_got = WSTRB;
            chk("wdata", WDATA, cur.wdata);
            chk("wstrb", {28'd0, WSTRB}, {28'd0, cur.mask});
          end
          w_cnt++;
        end
        if (BREADY && aw_f && w_f && !b_f) begin
          if (b_cnt >= cur.b_w) begin
            BVALID = 1; BRESP = cur.resp; b_f = 1;
            if (cur.resp == 2'b00)
              for (int b = 0; b < 4; b++)
                if (s_got[b]) resp_mem[aw_got[5:2]][8*b +: 8] = w_got[8*b +: 8];
          end
          b_cnt++;
        end
      end
    end
  end

  // Issues one request at a negedge; the reference model derives the expected response and cycle.
  task automatic issue(input plan_t p, input bit push, output int t_acc);
    exp_t e;
    bit   mis;
    int   guard;
    int   idx;
    mis = (p.size == 2'd1 && p.addr[0]) || (p.size >= 2'd2 && p.addr[1:0] != 2'b00);
    p.nobus = MISALIGN_ON && mis;
    cur = p;
    req_valid = 1; req_wen = p.wen; req_size = p.size;
    req_addr = p.addr; req_wdata = p.wdata; req_wmask = p.mask;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    t_acc = cyc;
    idx = int'(p.addr[5:2]);
    e.rdata = 32'd0;
    if (p.nobus) begin
      e.err = 1'b1;
      e.lat = t_acc + 1;
    end else if (p.wen) begin
      e.err = (p.resp != 2'b00);
      e.lat = t_acc + 3 + ((p.aw_w > p.w_w) ? p.aw_w : p.w_w) + p.b_w;
      if (push && !e.err)
        for (int b = 0; b < 4; b++)
          if (p.mask[b]) model_mem[idx][8*b +: 8] = p.wdata[8*b +: 8];
    end else begin
      e.err = (p.resp != 2'b00);
      e.lat = t_acc + 3 + p.ar_w + p.r_w;
      if (!e.err) e.rdata = model_mem[idx];
    end
    if (push) exp_q.push_back(e);
    $display("req cycle %0d %s size=%0d addr=0x%08h wdata=0x%08h mask=0x%h resp=%0d",
             t_acc, p.wen ? "ST" : "LD", p.size, p.addr, p.wdata, p.mask, p.resp);
    @(negedge clk);
    // Garbage held with req_valid high while busy must be ignored.
    req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom); req_wen = 1'($urandom);
    chk("req_ready_after_accept", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int n0);
    int guard;
    guard = 0;
    while (rsp_cnt <= n0 && guard < 300) begin @(negedge clk); guard++; end
    chk("rsp_arrived", {31'd0, rsp_cnt > n0}, 32'd1);
  endtask

  function automatic plan_t mk(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, input logic [1:0] resp);
    plan_t p;
    p.wen = wen; p.size = 2'd2; p.addr = addr; p.wdata = wdata; p.mask = mask; p.resp = resp;
    p.ar_w = 0; p.r_w = 0; p.aw_w = 0; p.w_w = 0; p.b_w = 0; p.nobus = 0;
    return p;
  endfunction

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    plan_t p;
    int    t, n0, guard;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0101);
      resp_mem[i]  = model_mem[i];
    end
    model_mem[14] = 32'h0000_1234;
    resp_mem[14]  = 32'h0000_1234;
    cur = mk(0, 0, 0, 0, 0);
    rst = 1; req_valid = 0; req_wen = 0; req_size = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("rst_wvalid",  {31'd0, WVALID},  32'd0);
    chk("rst_rready",  {31'd0, RREADY},  32'd0);
    chk("rst_bready",  {31'd0, BREADY},  32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_rsp_rdata", rsp_rdata, 32'd0);
    chk("idle_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Zero-wait load, response at T+3.
    n0 = rsp_cnt; issue(mk(0, 32'h0200_BFF8, 0, 0, 0), 1, t); wait_rsp(n0);
    // Store where AW is taken three cycles before W, then read it back.
    p = mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0); p.w_w = 3; p.b_w = 1;
    @(negedge clk); n0 = rsp_cnt; issue(p, 1, t); wait_rsp(n0);
    @(negedge clk); n0 = rsp_cnt; issue(mk(0, 32'h8000_0010, 0, 0, 0), 1, t); wait_rsp(n0);
    // Error responses.
    @(negedge clk); n0 = rsp_cnt; issue(mk(0, 32'h8000_0020, 0, 0, 2'b10), 1, t); wait_rsp(n0);
    @(negedge clk); n0 = rsp_cnt; issue(mk(1, 32'h8000_0024, 32'h1111_2222, 4'hF, 2'b10), 1, t); wait_rsp(n0);
    @(negedge clk); n0 = rsp_cnt; issue(mk(1, 32'h8000_0028, 32'h3333_4444, 4'h3, 2'b11), 1, t); wait_rsp(n0);
    @(negedge clk); n0 = rsp_cnt; issue(mk(0, 32'h8000_0024, 0, 0, 0), 1, t); wait_rsp(n0);
    // ARREADY held low for five cycles.
    p = mk(0, 32'h8000_0030, 0, 0, 0); p.ar_w = 5;
    @(negedge clk); n0 = rsp_cnt; issue(p, 1, t); wait_rsp(n0);

    // Reset while waiting in B: transaction abandoned, no response.
    p = mk(1, 32'h8000_0034, 32'hCAFE_F00D, 4'hF, 0); p.b_w = 20;
    @(negedge clk); issue(p, 0, t);
    guard = 0;
    while (!BREADY && guard < 50) begin @(negedge clk); guard++; end
    chk("reached_b", {31'd0, BREADY}, 32'd1);
    #1 rst = 1;
    @(negedge clk);
    chk("rstb_bready", {31'd0, BREADY}, 32'd0);
    chk("rstb_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("rstb_wvalid", {31'd0, WVALID}, 32'd0);
    chk("rstb_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #1 rst = 0;
    @(negedge clk);
    chk("rstb_idle", {31'd0, req_ready}, 32'd1);
    chk("rstb_rsp_valid2", {31'd0, rsp_valid}, 32'd0);

    // Misaligned word load.
    @(negedge clk); saw_bus = 0; n0 = rsp_cnt;
    issue(mk(0, 32'h8000_0002, 0, 0, 0), 1, t); wait_rsp(n0);
    chk("misalign_bus_activity", {31'd0, saw_bus}, {31'd0, !MISALIGN_ON});

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      p.wen   = 1'($urandom_range(0, 1));
      p.size  = 2'($urandom_range(0, 3));
      p.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) p.addr[1:0] = 2'b00;
      p.wdata = $urandom;
      p.mask  = 4'($urandom);
      p.resp  = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      p.ar_w  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      p.r_w   = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      p.aw_w  = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      p.w_w   = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      p.b_w   = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      p.nobus = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      n0 = rsp_cnt; issue(p, 1, t); wait_rsp(n0);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
